// File: rtl/hash_byte_out_pkg.sv
// Shared definitions for the BLAKE2b byte-wide digest transmitter.
// Digest sizing, the FSM encoding and the nn length convention live here.
package hash_byte_out_pkg;

    localparam int BYTES = 64;
    localparam int CNT_W = 6;
    localparam int LEN_W = CNT_W + 1;

    // A configured digest length of zero means the full 64-byte digest.
    localparam bit NN_ZERO_IS_64 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [LEN_W-1:0] nn_to_len(input logic [CNT_W-1:0] nn);
        if (NN_ZERO_IS_64 && nn == '0) begin
            return LEN_W'(BYTES);
        end
        return {1'b0, nn};
    endfunction

endpackage

// File: rtl/hash_shift_buf.sv
// 512-bit digest buffer: parallel load, byte-wise right shift, or clear.
// The low byte is always the next byte to transmit.
module hash_shift_buf
    import hash_byte_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 clear,
    input  logic [8*BYTES-1:0]   d,
    output logic [7:0]           q
);

    logic [8*BYTES-1:0] data;

    // A new digest wins over retiring the old one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data <= '0;
        end else if (load) begin
            data <= d;
        end else if (clear) begin
            data <= '0;
        end else if (shift) begin
            data <= {8'h00, data[8*BYTES-1:8]};
        end
    end

    assign q = data[7:0];

endmodule

// File: rtl/hash_byte_out.sv
// Streams the first nn bytes of a captured BLAKE2b digest, LSB first.
// Accepts a new digest during the final byte so back-to-back streams have no gap.
module hash_byte_out
    import hash_byte_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 en_i,
    input  logic [CNT_W-1:0]     nn_i,
    input  logic                 h_v_i,
    input  logic [8*BYTES-1:0]   h_i,
    output logic                 h_ready_o,
    output logic                 busy_o,
    output logic                 ovf_o,
    output logic                 hash_v_o,
    output logic [7:0]           hash_o
);

    state_t             state;
    logic               en_q;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   len;
    logic               ovf;
    logic               last;
    logic               capture;

    assign last      = (state == SEND) && en_q && ({1'b0, cnt} == len - LEN_W'(1));
    assign h_ready_o = (state == IDLE) || last;
    assign capture   = h_v_i && h_ready_o;
    assign busy_o    = (state == SEND);
    assign hash_v_o  = (state == SEND) && en_q;
    assign ovf_o     = ovf;

    // Clearing on the final byte leaves hash_o at zero while idle.
    hash_shift_buf u_buf (
        .clk    (clk),
        .nreset (nreset),
        .load   (capture),
        .shift  (hash_v_o),
        .clear  (last),
        .d      (h_i),
        .q      (hash_o)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            en_q  <= 1'b0;
            cnt   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
        end else begin
            en_q <= en_i;
            if (h_v_i && !h_ready_o) begin
                ovf <= 1'b1;
            end
            if (capture) begin
                state <= SEND;
                len   <= nn_to_len(nn_i);
                cnt   <= '0;
            end else if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == SEND && en_q) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_byte_out.sv
// Self-checking bench for hash_byte_out against a queue-based byte-stream model.
// Directed scenarios plus a randomized run with random enables, lengths and pulses.
module tb_hash_byte_out;

    logic         clk = 1'b0;
    logic         nreset;
    logic         en_i;
    logic [5:0]   nn_i;
    logic         h_v_i;
    logic [511:0] h_i;
    logic         h_ready_o;
    logic         busy_o;
    logic         ovf_o;
    logic         hash_v_o;
    logic [7:0]   hash_o;

    int checks = 0;
    int errors = 0;

    // Model: bytes still owed to the output, the delayed enable and the overflow flag.
    byte unsigned pend[$];
    logic         en_q_m;
    logic         ovf_m;

    // {h_ready, busy, ovf, hash_v, hash[7:0]}
    logic [11:0]  obs;
    logic [11:0]  expv;

    hash_byte_out dut (
        .clk       (clk),
        .nreset    (nreset),
        .en_i      (en_i),
        .nn_i      (nn_i),
        .h_v_i     (h_v_i),
        .h_i       (h_i),
        .h_ready_o (h_ready_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o),
        .hash_v_o  (hash_v_o),
        .hash_o    (hash_o)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pattern(input logic [7:0] base);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [511:0] rand_h();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [11:0] model_out();
        logic busy;
        logic rdy;
        logic [7:0] b;
        busy = (pend.size() != 0);
        rdy  = !busy || (en_q_m && pend.size() == 1);
        b    = busy ? 8'(pend[0]) : 8'h00;
        return {rdy, busy, ovf_m, busy && en_q_m, b};
    endfunction

    task automatic model_reset();
        pend.delete();
        en_q_m = 1'b0;
        ovf_m  = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic hv, input logic [5:0] nn, input logic [511:0] h);
        logic [11:0] o;
        int len;
        o = model_out();
        if (en_q_m && pend.size() != 0) void'(pend.pop_front());
        if (hv) begin
            if (o[11]) begin
                len = (nn == 0) ? 64 : int'(nn);
                for (int k = 0; k < len; k++) pend.push_back(h[8*k +: 8]);
            end else begin
                ovf_m = 1'b1;
            end
        end
        en_q_m = en;
    endtask

    // Drive one cycle's inputs, sample outputs, then advance the model over the edge.
    task automatic applyStimulus(input logic en, input logic hv, input logic [5:0] nn, input logic [511:0] h);
        en_i  = en;
        h_v_i = hv;
        nn_i  = nn;
        h_i   = h;
        obs   = {h_ready_o, busy_o, ovf_o, hash_v_o, hash_o};
        expv  = model_out();
        @(posedge clk);
        model_edge(en, hv, nn, h);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        en_i = 1'b0; h_v_i = 1'b0; nn_i = '0; h_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        obs = {h_ready_o, busy_o, ovf_o, hash_v_o, hash_o};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int nv = 0;
        applyStimulus(1'b1, 1'b1, 6'd32, pattern(8'h00));
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, 1'b0, 6'd32, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (obs[8]) begin
                checks++;
                if (obs[7:0] !== 8'(nv)) begin
                    errors++;
                    $display("[TB] FAIL basic_byte idx=%0d got=%h exp=%h", nv, obs[7:0], 8'(nv));
                end
                nv++;
            end
        end
        checks++;
        if (nv != 32) begin
            errors++;
            $display("[TB] FAIL basic_count got=%0d exp=32", nv);
        end
    endtask

    task automatic test_full64();
        int nv = 0;
        int nr = 0;
        applyStimulus(1'b1, 1'b1, 6'd0, pattern(8'h00));
        for (int c = 0; c < 70; c++) begin
            applyStimulus(1'b1, 1'b0, 6'd0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL full64 cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (obs[8]) nv++;
            if (!obs[11]) nr++;
        end
        checks++;
        if (nv != 64 || nr != 63) begin
            errors++;
            $display("[TB] FAIL full64_counts got valid=%0d notready=%0d exp valid=64 notready=63", nv, nr);
        end
    endtask

    task automatic test_pause();
        int nv = 0;
        logic en;
        applyStimulus(1'b1, 1'b1, 6'd10, pattern(8'h00));
        for (int c = 0; c < 20; c++) begin
            en = !(c >= 4 && c <= 6);
            applyStimulus(en, 1'b0, 6'd10, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL pause cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (obs[8:0] !== {1'b0, 8'h05}) begin
                    errors++;
                    $display("[TB] FAIL pause_hold cyc=%0d got=%h exp=%h", c, obs[8:0], {1'b0, 8'h05});
                end
            end
            if (obs[8]) nv++;
        end
        checks++;
        if (nv != 10) begin
            errors++;
            $display("[TB] FAIL pause_count got=%0d exp=10", nv);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        applyStimulus(1'b1, 1'b1, 6'd4, pattern(8'h00));
        for (int c = 0; c < 12; c++) begin
            if (c == 3) applyStimulus(1'b1, 1'b1, 6'd4, pattern(8'hA0));
            else        applyStimulus(1'b1, 1'b0, 6'd4, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL b2b cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (c < 8) begin
                checks++;
                if (obs[9:0] !== {1'b0, 1'b1, want[c]}) begin
                    errors++;
                    $display("[TB] FAIL b2b_seq cyc=%0d got=%h exp=%h", c, obs[9:0], {1'b0, 1'b1, want[c]});
                end
            end
        end
    endtask

    task automatic test_overflow();
        int nv = 0;
        applyStimulus(1'b1, 1'b1, 6'd8, pattern(8'h00));
        for (int c = 0; c < 14; c++) begin
            if (c == 2) applyStimulus(1'b1, 1'b1, 6'd3, rand_h());
            else        applyStimulus(1'b1, 1'b0, 6'd8, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL overflow cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (obs[8]) begin
                checks++;
                if (obs[7:0] !== 8'(nv)) begin
                    errors++;
                    $display("[TB] FAIL overflow_byte idx=%0d got=%h exp=%h", nv, obs[7:0], 8'(nv));
                end
                nv++;
            end
        end
        checks++;
        if (nv != 8 || ovf_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_end got valid=%0d ovf=%b exp valid=8 ovf=1", nv, ovf_o);
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(1'b1, 1'b1, 6'd16, pattern(8'h00));
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 6'd16, '0);
        nreset = 1'b0;
        #1;
        obs = {h_ready_o, busy_o, ovf_o, hash_v_o, hash_o};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL async_reset got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        model_reset();
        #2;
        nreset = 1'b1;
        applyStimulus(1'b1, 1'b0, 6'd5, '0);
        applyStimulus(1'b1, 1'b1, 6'd5, pattern(8'h40));
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 6'd5, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL post_reset cyc=%0d got=%h exp=%h", c, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        logic en;
        logic hv;
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) < 8);
            hv = ($urandom_range(0, 19) == 0);
            applyStimulus(en, hv, 6'($urandom_range(0, 63)), rand_h());
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", c, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full64();
        test_pause();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
